fetch_unit: RTL and testbench

Instruction fetch stage of the 8-bit core: owns the program counter, fetches 16-bit instruction words from program memory over a request/acknowledge handshake, and presents each word to the instruction decoder. The decoder's flow-control outputs (`cnt_wr_en`, `add_offset`, `literal_adr`) close the loop: this block consumes them to select the next PC (sequential, absolute GOTO, or relative branch).

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Program-memory fetch bus between the fetch stage (master) and program memory (slave).
//   mem_req  : fetch request, held high until the acknowledge edge
//   mem_addr : fetch address, equals the program counter while mem_req is high
//   mem_ack  : memory word valid on mem_data (may respond combinationally)
//   mem_data : fetched instruction word
interface fetch_unit_if #(
  parameter int unsigned PC_WIDTH          = 8,
  parameter int unsigned PROGRAM_DataWidth = 16
) ();

  logic                         mem_req;
  logic [PC_WIDTH-1:0]          mem_addr;
  logic                         mem_ack;
  logic [PROGRAM_DataWidth-1:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the 8-bit core. Owns the program counter, fetches
// instruction words over a request/acknowledge handshake and presents them to
// the decoder; the decoder's flow-control outputs select the next PC.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   mem_if       : program-memory fetch bus (master side)
//   instruction  : instruction register driving the decoder
//   instr_valid  : high in the execute cycle, qualifies downstream writes
//   pc           : address of the instruction held / being fetched
//   stall        : freezes the execute cycle
//   cnt_wr_en    : decoder requests a PC load from the branch target
//   add_offset   : branch target is pc + sign-extended literal_adr
//   literal_adr  : absolute target or signed relative offset
module fetch_unit #(
  parameter int unsigned PC_WIDTH          = 8,
  parameter int unsigned PROGRAM_DataWidth = 16,
  parameter int unsigned DataWidth         = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  fetch_unit_if.master                 mem_if,
  output logic [PROGRAM_DataWidth-1:0] instruction,
  output logic                         instr_valid,
  output logic [PC_WIDTH-1:0]          pc,
  input  logic                         stall,
  input  logic                         cnt_wr_en,
  input  logic                         add_offset,
  input  logic [DataWidth-1:0]         literal_adr
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  state_e                       state_q;
  logic [PC_WIDTH-1:0]          pc_q;
  logic [PC_WIDTH-1:0]          pc_d;
  logic [PROGRAM_DataWidth-1:0] instr_q;
  logic                         instr_valid_q;
  logic                         mem_req_q;

  // Next-PC select; only consumed on the non-stalled EXEC edge.
  // Relative targets are computed from the branch instruction's own address.
  always_comb begin
    pc_d = pc_q + PC_WIDTH'(1);
    if (cnt_wr_en) begin
      if (add_offset) begin
        pc_d = pc_q + PC_WIDTH'($signed(literal_adr));
      end else begin
        pc_d = PC_WIDTH'(literal_adr);
      end
    end
  end

  // Fetch/execute sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RST;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      mem_req_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_RST: begin
          state_q   <= ST_FETCH;
          mem_req_q <= 1'b1;
        end
        ST_FETCH: begin
          if (mem_if.mem_ack) begin
            instr_q       <= mem_if.mem_data;
            state_q       <= ST_EXEC;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          // Request for the new PC goes out the very next cycle, so no
          // wrong-path fetch can be issued.
          if (!stall) begin
            pc_q          <= pc_d;
            state_q       <= ST_FETCH;
            mem_req_q     <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_RST;
          mem_req_q     <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The address is the PC itself: stable for the whole request and zero in reset.
  assign mem_if.mem_req  = mem_req_q;
  assign mem_if.mem_addr = pc_q;
  assign instruction     = instr_q;
  assign instr_valid     = instr_valid_q;
  assign pc              = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cases followed by randomized instruction
// streams (wait states, stalls, branches, resets) checked against a
// transaction-level model of the PC and instruction register.
module tb_fetch_unit;

  localparam int unsigned PC_W = 8;
  localparam int unsigned IW   = 16;
  localparam int unsigned LW   = 8;

  logic            clk;
  logic            reset;
  logic [IW-1:0]   instruction;
  logic            instr_valid;
  logic [PC_W-1:0] pc;
  logic            stall;
  logic            cnt_wr_en;
  logic            add_offset;
  logic [LW-1:0]   literal_adr;

  fetch_unit_if #(.PC_WIDTH(PC_W), .PROGRAM_DataWidth(IW)) mem_if ();

  fetch_unit #(
    .PC_WIDTH(PC_W), .PROGRAM_DataWidth(IW), .DataWidth(LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_if     (mem_if.master),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .pc         (pc),
    .stall      (stall),
    .cnt_wr_en  (cnt_wr_en),
    .add_offset (add_offset),
    .literal_adr(literal_adr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: where the program should be and what the decoder should see.
  logic [PC_W-1:0] exp_pc;
  logic [IW-1:0]   exp_instr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural next-PC rule in plain integer arithmetic, modulo 256.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] cur, input logic br,
                                               input logic rel, input logic [LW-1:0] lit);
    int t;
    if (!br)      t = int'(cur) + 1;
    else if (!rel) t = int'(lit);
    else          t = int'(cur) + ((int'(lit) >= 128) ? int'(lit) - 256 : int'(lit));
    return PC_W'(t & 255);
  endfunction

  // One instruction, entered at a negedge where the DUT should be fetching.
  task automatic run_instr(input int waits, input int stalls, input logic br,
                           input logic rel, input logic [LW-1:0] lit, input logic rnd_lo);
    logic [IW-1:0] word;
    word = {exp_pc, rnd_lo ? 8'($urandom) : 8'h00};
    for (int w = 0; w <= waits; w++) begin
      check_eq("fetch_req", 32'(mem_if.mem_req), 32'd1);
      check_eq("fetch_addr", 32'(mem_if.mem_addr), 32'(exp_pc));
      check_eq("fetch_valid", 32'(instr_valid), 32'd0);
      check_eq("fetch_instr_hold", 32'(instruction), 32'(exp_instr));
      mem_if.mem_ack  = (w == waits);
      mem_if.mem_data = (w == waits) ? word : 16'(~word);
      stall           = 1'($urandom);
      cnt_wr_en       = 1'($urandom);
      add_offset      = 1'($urandom);
      literal_adr     = 8'($urandom);
      @(negedge clk);
    end
    exp_instr = word;
    for (int s = 0; s <= stalls; s++) begin
      check_eq("exec_req", 32'(mem_if.mem_req), 32'd0);
      check_eq("exec_valid", 32'(instr_valid), 32'd1);
      check_eq("exec_instr", 32'(instruction), 32'(exp_instr));
      check_eq("exec_pc", 32'(pc), 32'(exp_pc));
      // Acks outside FETCH must be ignored.
      mem_if.mem_ack  = 1'($urandom);
      mem_if.mem_data = 16'($urandom);
      if (s < stalls) begin
        stall       = 1'b1;
        cnt_wr_en   = 1'($urandom);
        add_offset  = 1'($urandom);
        literal_adr = 8'($urandom);
      end else begin
        stall       = 1'b0;
        cnt_wr_en   = br;
        add_offset  = rel;
        literal_adr = lit;
      end
      @(negedge clk);
    end
    exp_pc = next_pc(exp_pc, br, rel, lit);
  endtask

  // Reset asserted during a fetch, coincident with an ack carrying data.
  task automatic reset_mid_fetch(input logic [IW-1:0] data);
    reset           = 1'b1;
    mem_if.mem_ack  = 1'b1;
    mem_if.mem_data = data;
    stall           = 1'($urandom);
    @(negedge clk);
    check_eq("rst_req", 32'(mem_if.mem_req), 32'd0);
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_addr", 32'(mem_if.mem_addr), 32'd0);
    check_eq("rst_instr", 32'(instruction), 32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    reset          = 1'b0;
    mem_if.mem_ack = 1'b0;
    @(negedge clk);
    exp_pc    = '0;
    exp_instr = '0;
  endtask

  initial begin
    reset           = 1'b1;
    stall           = 1'b0;
    cnt_wr_en       = 1'b0;
    add_offset      = 1'b0;
    literal_adr     = '0;
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_data = '0;
    exp_pc          = '0;
    exp_instr       = '0;

    // Two reset cycles, outputs at their reset values.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("reset_req", 32'(mem_if.mem_req), 32'd0);
      check_eq("reset_pc", 32'(pc), 32'd0);
      check_eq("reset_instr", 32'(instruction), 32'd0);
      check_eq("reset_valid", 32'(instr_valid), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Sequential zero-wait fetches: addresses 0,1,2,3.
    run_instr(0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    run_instr(0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    run_instr(0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("seq_instr_0200", 32'(instruction), 32'h0200);
    // Absolute GOTO 0x05, then 0x3F, then 0xFF and wrap to 0x00.
    run_instr(0, 0, 1'b1, 1'b0, 8'h05, 1'b0);
    run_instr(0, 0, 1'b1, 1'b0, 8'h3F, 1'b0);
    check_eq("goto_3f", 32'(mem_if.mem_addr), 32'h3F);
    run_instr(0, 0, 1'b1, 1'b0, 8'hFF, 1'b0);
    run_instr(0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("wrap_00", 32'(mem_if.mem_addr), 32'h00);
    // Relative branches: 0x10+9, 0x02-4, and add_offset without cnt_wr_en.
    run_instr(0, 0, 1'b1, 1'b0, 8'h10, 1'b0);
    run_instr(0, 0, 1'b1, 1'b1, 8'h09, 1'b0);
    check_eq("rel_19", 32'(mem_if.mem_addr), 32'h19);
    run_instr(0, 0, 1'b1, 1'b0, 8'h02, 1'b0);
    run_instr(0, 0, 1'b1, 1'b1, 8'hFC, 1'b0);
    check_eq("rel_fe", 32'(mem_if.mem_addr), 32'hFE);
    run_instr(0, 0, 1'b1, 1'b0, 8'h10, 1'b0);
    run_instr(0, 0, 1'b0, 1'b1, 8'h40, 1'b0);
    check_eq("noload_11", 32'(mem_if.mem_addr), 32'h11);
    // Three wait states, then a two-cycle stall.
    run_instr(3, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    run_instr(0, 2, 1'b0, 1'b0, 8'h00, 1'b1);
    // Reset coincident with an ack, then refetch from 0.
    reset_mid_fetch(16'hA5A5);
    run_instr(0, 0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_mid_fetch(16'($urandom));
      end
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                1'($urandom), 1'($urandom), 8'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
